median_filter_3x3: RTL
======================

MEDIAN_FILTER_3X3 -- requirements
Module: median_filter_3x3

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 640, pixels per line; legal range 3..4096.
REQ-003 Parameter IMG_H, default 480, lines per frame; legal range 3..4096.
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_vld  input  1  in_data valid this cycle; no backpressure, every valid beat is accepted.
REQ-007 Port in_sof  input  1  start of frame; meaningful only when in_vld=1; marks pixel (row 0, col 0).
REQ-008 Port in_data  input  DATA_W  input pixel, raster order.
REQ-009 Port sel  input  2  operator select: 0 median, 1 minimum, 2 maximum, 3 centre pass-through.
REQ-010 Port out_vld  output  1  out_data valid this cycle.
REQ-011 Port out_data  output  DATA_W  filtered pixel.

Function
REQ-012 Two line buffers of IMG_W x DATA_W shall hold the previous two lines; with three column taps they form a 3x3 window, rows r-2..r, columns c-2..c.
REQ-013 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) shall advance only on accepted beats; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
REQ-014 An accepted beat with in_sof=1 shall be taken as row 0, col 0, overriding the counters (resynchronisation), and the next beat shall be col 1.
REQ-015 A window shall be emitted only for accepted beats with row>=2 and col>=2; the output is centred at (row-1, col-1); (IMG_H-2)x(IMG_W-2) outputs per frame; no border outputs.
REQ-016 Windows shall never mix pixels across line boundaries: the column taps shall be gated by col>=2, not by beat count.
REQ-017 Pipeline: stage W registers the window and sel; stage S1 sorts each row into max/mid/min; stage S2 computes min-of-maxes, mid-of-mids, max-of-mins, plus global min and max; stage S3 computes the median of the three S2 values and applies the selected operator.
REQ-018 Latency shall be fixed at 4 rising edges: a beat accepted at edge k gives out_vld=1 with its result in the cycle following edge k+4.
REQ-019 The pipeline shall advance every cycle; a valid bit travels with each stage; in_vld gaps produce out_vld gaps, and results keep their order.
REQ-020 sel shall be sampled with the window at stage W; changing sel affects only windows sampled afterwards.
REQ-021 Comparisons shall be unsigned over DATA_W bits; the result is one of the nine window pixels, with no rounding and no width growth.
REQ-022 Ties: equal values are interchangeable; the result shall equal the true 5th-smallest, minimum, or maximum of the nine values.
REQ-023 out_data shall hold its last value when out_vld=0.

Reset
REQ-024 While rst_n=0: out_vld=0, out_data=0, col=0, row=0, all stage valid bits 0, all window and stage registers 0.
REQ-025 Line buffer contents need not be reset; no output may depend on them until two lines after reset or in_sof have been written.
REQ-026 Reset asserted mid-frame shall discard in-flight results; the first frame after release shall start at an in_sof beat or at the first accepted beat, taken as row 0, col 0.

Verification (IMG_W=5, IMG_H=5, DATA_W=8)
REQ-027 Constant frame, all pixels 0x40, sel=0, continuous in_vld -> exactly 9 out_vld pulses, each 0x40; first pulse 4 edges after pixel (2,2).
REQ-028 Pixel value = row*5+col, sel=0 -> outputs 6,7,8,11,12,13,16,17,18; sel=1 -> 0,1,2,5,6,7,10,11,12; sel=2 -> 12,13,14,17,18,19,22,23,24; sel=3 -> same as sel=0 here.
REQ-029 Impulse frame, all 0x10 except (2,2)=0xFF, sel=0 -> all 9 outputs 0x10; with sel=2 -> all 9 outputs 0xFF.
REQ-030 Ramp of REQ-028 with in_vld toggled 1,0,1,0 -> same 9 values in the same order; each out_vld 4 edges after its completing beat.
REQ-031 in_sof asserted at frame 1, col 3 of row 2 -> counters restart; no window spans the resync; the next 9 outputs match a clean frame.
REQ-032 rst_n pulsed low at the 15th beat -> out_vld=0 immediately; no stale outputs after release; the following clean frame gives the 9 correct values.

Source files
------------

// File: rtl/median_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module      : median_filter_3x3
// Description : Streaming 3x3 median / min / max / centre filter over a raster
//               image held in two line buffers; fixed 4-edge latency.
// Revision    : 1.0 - initial release
// ============================================================================
module median_filter_3x3 #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        sel,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   localparam int            c_CW       = $clog2(IMG_W);
   localparam int            c_RW       = $clog2(IMG_H);
   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
   localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
   localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
   localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);
   localparam logic [c_CW-1:0] c_COL_ONE  = c_CW'(1);
   localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

   typedef logic [DATA_W-1:0] pix_t;

   function automatic pix_t f_min(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t f_max(input pix_t a, input pix_t b);
      return (a < b) ? b : a;
   endfunction

   function automatic pix_t f_mid3(input pix_t a, input pix_t b, input pix_t c);
      return f_max(f_min(a, b), f_min(f_max(a, b), c));
   endfunction

   function automatic pix_t f_min3(input pix_t a, input pix_t b, input pix_t c);
      return f_min(f_min(a, b), c);
   endfunction

   function automatic pix_t f_max3(input pix_t a, input pix_t b, input pix_t c);
      return f_max(f_max(a, b), c);
   endfunction

   logic [c_CW-1:0] r_col;
   logic [c_RW-1:0] r_row;
   logic [c_CW-1:0] w_cur_col;
   logic [c_RW-1:0] w_cur_row;
   logic            w_win_vld;
   pix_t            w_tap [3];

   pix_t r_lb1 [IMG_W];
   pix_t r_lb2 [IMG_W];
   pix_t r_p1  [3];
   pix_t r_p2  [3];

   // in_sof forces the current beat to (0,0) regardless of the counters
   assign w_cur_col = in_sof ? '0 : r_col;
   assign w_cur_row = in_sof ? '0 : r_row;
   assign w_win_vld = in_vld && (w_cur_row >= c_ROW_TWO) && (w_cur_col >= c_COL_TWO);
   assign w_tap[0]  = r_lb2[w_cur_col];
   assign w_tap[1]  = r_lb1[w_cur_col];
   assign w_tap[2]  = in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (in_vld) begin
         if (w_cur_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= (w_cur_row == c_ROW_LAST) ? '0 : w_cur_row + c_ROW_ONE;
         end else begin
            r_col <= w_cur_col + c_COL_ONE;
            r_row <= w_cur_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_vld) begin
         r_lb1[w_cur_col] <= in_data;
         r_lb2[w_cur_col] <= r_lb1[w_cur_col];
      end
   end

   pix_t       r_win [9];
   logic       r_w_vld;
   logic [1:0] r_w_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            r_p1[i] <= '0;
            r_p2[i] <= '0;
         end
         for (int i = 0; i < 9; i++) r_win[i] <= '0;
         r_w_vld <= 1'b0;
         r_w_sel <= '0;
      end else begin
         r_w_vld <= w_win_vld;
         if (in_vld) begin
            for (int i = 0; i < 3; i++) begin
               r_p1[i] <= w_tap[i];
               r_p2[i] <= r_p1[i];
            end
         end
         if (w_win_vld) begin
            for (int i = 0; i < 3; i++) begin
               r_win[i*3+0] <= r_p2[i];
               r_win[i*3+1] <= r_p1[i];
               r_win[i*3+2] <= w_tap[i];
            end
            r_w_sel <= sel;
         end
      end
   end

   pix_t       r_s1_max [3];
   pix_t       r_s1_mid [3];
   pix_t       r_s1_min [3];
   pix_t       r_s1_ctr, r_s2_ctr, r_s3_ctr;
   pix_t       r_s2_a, r_s2_b, r_s2_c, r_s2_gmin, r_s2_gmax;
   pix_t       r_s3_med, r_s3_gmin, r_s3_gmax;
   logic       r_s1_vld, r_s2_vld, r_s3_vld;
   logic [1:0] r_s1_sel, r_s2_sel, r_s3_sel;
   pix_t       w_op;

   // Row sort, then min-of-max / mid-of-mid / max-of-min: median is their mid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            r_s1_max[i] <= '0;
            r_s1_mid[i] <= '0;
            r_s1_min[i] <= '0;
         end
         {r_s1_ctr, r_s2_ctr, r_s3_ctr}           <= '0;
         {r_s2_a, r_s2_b, r_s2_c}                 <= '0;
         {r_s2_gmin, r_s2_gmax}                   <= '0;
         {r_s3_med, r_s3_gmin, r_s3_gmax}         <= '0;
         {r_s1_vld, r_s2_vld, r_s3_vld}           <= '0;
         {r_s1_sel, r_s2_sel, r_s3_sel}           <= '0;
         out_vld  <= 1'b0;
         out_data <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_s1_max[i] <= f_max3(r_win[i*3], r_win[i*3+1], r_win[i*3+2]);
            r_s1_mid[i] <= f_mid3(r_win[i*3], r_win[i*3+1], r_win[i*3+2]);
            r_s1_min[i] <= f_min3(r_win[i*3], r_win[i*3+1], r_win[i*3+2]);
         end
         r_s1_ctr  <= r_win[4];
         r_s1_sel  <= r_w_sel;
         r_s1_vld  <= r_w_vld;

         r_s2_a    <= f_min3(r_s1_max[0], r_s1_max[1], r_s1_max[2]);
         r_s2_b    <= f_mid3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
         r_s2_c    <= f_max3(r_s1_min[0], r_s1_min[1], r_s1_min[2]);
         r_s2_gmin <= f_min3(r_s1_min[0], r_s1_min[1], r_s1_min[2]);
         r_s2_gmax <= f_max3(r_s1_max[0], r_s1_max[1], r_s1_max[2]);
         r_s2_ctr  <= r_s1_ctr;
         r_s2_sel  <= r_s1_sel;
         r_s2_vld  <= r_s1_vld;

         r_s3_med  <= f_mid3(r_s2_a, r_s2_b, r_s2_c);
         r_s3_gmin <= r_s2_gmin;
         r_s3_gmax <= r_s2_gmax;
         r_s3_ctr  <= r_s2_ctr;
         r_s3_sel  <= r_s2_sel;
         r_s3_vld  <= r_s2_vld;

         out_vld <= r_s3_vld;
         if (r_s3_vld) out_data <= w_op;
      end
   end

   always_comb begin
      w_op = r_s3_ctr;
      case (r_s3_sel)
         2'd0:    w_op = r_s3_med;
         2'd1:    w_op = r_s3_gmin;
         2'd2:    w_op = r_s3_gmax;
         default: w_op = r_s3_ctr;
      endcase
   end

endmodule
`default_nettype wire
